// File: rtl/sha256_host_pkg.sv
// rtl/sha256_host_pkg.sv - shared types and widths for the SHA-256 memory host
package sha256_host_pkg;
  localparam int HASH_WORDS = 8;
  localparam int WORD_W = 32;
  localparam int MEM_ADDR_W = 16;

  typedef enum logic [2:0] {
    LOAD,
    KICK,
    ACK,
    RUN,
    DUMP_RD,
    DUMP
  } host_state_t;
endpackage

// File: rtl/sha256_word_ram.sv
// rtl/sha256_word_ram.sv - single-port read-first word RAM with registered read
module sha256_word_ram
  import sha256_host_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  // Read-first: a same-cycle write is not visible on rdata until the next read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sha256_mem_host.sv
// rtl/sha256_mem_host.sv - RAM responder and job harness for one sha256 engine; SHA_HOST_WDOG_EN adds a run timeout
module sha256_mem_host
  import sha256_host_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int NUM_OF_WORDS = 20,
  parameter logic [MEM_ADDR_W-1:0] MESSAGE_ADDR = 16'h0000,
  parameter logic [MEM_ADDR_W-1:0] OUTPUT_ADDR = 16'h0080,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  start,
  input  logic                  done,
  output logic [MEM_ADDR_W-1:0] message_addr,
  output logic [MEM_ADDR_W-1:0] output_addr,
  input  logic                  mem_we,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0]     mem_write_data,
  output logic [WORD_W-1:0]     mem_read_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  busy,
`ifdef SHA_HOST_WDOG_EN
  output logic                  timeout,
`endif
  output logic                  addr_err
);
  localparam int AW = $clog2(DEPTH);

  host_state_t state;
  logic [15:0] cnt;
  logic [2:0] k;
  logic eng_own, in_range, load_hs, eng_rd_ok_q;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
`ifdef SHA_HOST_WDOG_EN
  logic [31:0] wdog;
`endif

  assign message_addr = MESSAGE_ADDR;
  assign output_addr  = OUTPUT_ADDR;

  assign eng_own  = (state == KICK) || (state == ACK) || (state == RUN);
  assign in_range = {16'd0, mem_addr} < 32'(DEPTH);
  assign load_hs  = (state == LOAD) && in_valid && in_ready;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = OUTPUT_ADDR[AW-1:0] + AW'(k);
    ram_wdata = in_data;
    if (eng_own) begin
      ram_we    = mem_we && in_range;
      ram_addr  = mem_addr[AW-1:0];
      ram_wdata = mem_write_data;
    end else if (state == LOAD) begin
      ram_we   = load_hs;
      ram_addr = MESSAGE_ADDR[AW-1:0] + cnt[AW-1:0];
    end
  end

  sha256_word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The dump re-reads OUTPUT_ADDR+k every cycle, so ram_rdata holds steady under back-pressure.
  assign mem_read_data = eng_rd_ok_q ? ram_rdata : '0;
  assign out_data      = out_valid ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= LOAD;
      cnt         <= '0;
      k           <= '0;
      start       <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      addr_err    <= 1'b0;
      eng_rd_ok_q <= 1'b0;
`ifdef SHA_HOST_WDOG_EN
      timeout     <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      start       <= 1'b0;
      eng_rd_ok_q <= eng_own && in_range;
      if (eng_own && !in_range) addr_err <= 1'b1;
      case (state)
        LOAD: begin
          if (load_hs) begin
            if (cnt == 16'(NUM_OF_WORDS - 1)) begin
              cnt      <= '0;
              state    <= KICK;
              start    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        KICK: begin
          state <= ACK;
`ifdef SHA_HOST_WDOG_EN
          wdog  <= '0;
`endif
        end
        ACK, RUN: begin
          // ACK waits for the engine to leave idle, RUN for it to return.
          if ((state == ACK) ? !done : done) begin
            state <= (state == ACK) ? RUN : DUMP_RD;
            k     <= '0;
          end
`ifdef SHA_HOST_WDOG_EN
          else if (wdog == 32'(WDOG_CYCLES - 1)) begin
            state    <= LOAD;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            wdog <= wdog + 32'd1;
          end
`endif
        end
        DUMP_RD: begin
          state     <= DUMP;
          out_valid <= 1'b1;
        end
        DUMP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == 3'(HASH_WORDS - 1)) begin
              state    <= LOAD;
              cnt      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              k     <= k + 3'd1;
              state <= DUMP_RD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_mem_host.sv
// tb/tb_sha256_mem_host.sv - directed self-checking bench for sha256_mem_host
module tb_sha256_mem_host;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, done;
  logic [15:0] message_addr, output_addr;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        busy, addr_err;

  int n_checks = 0;
  int n_errors = 0;
  int start_pulses = 0;

  sha256_mem_host dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .done           (done),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset_n && start) start_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_job(input logic [31:0] base);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = base;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (i == 19) check_eq("in_ready_before_last", 32'(in_ready), 32'd1);
      in_data = base + 32'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("in_ready_after_last", 32'(in_ready), 32'd0);
    check_eq("start_pulse", 32'(start), 32'd1);
    check_eq("busy_in_kick", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("start_one_cycle", 32'(start), 32'd0);
  endtask

  task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_we = 1'b1;
    mem_addr = a;
    mem_write_data = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic eng_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    mem_we = 1'b0;
    mem_addr = a;
    @(negedge clk);
    check_eq(tag, mem_read_data, exp);
  endtask

  task automatic dump_words(input bit stall, input int nwords, input logic [31:0] base);
    for (int w = 0; w < nwords; w++) begin
      int t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        check_eq("dump_valid_timeout", 32'(out_valid), 32'd1);
        return;
      end
      check_eq("dump_word", out_data, base + 32'(w));
      if (stall) begin
        @(negedge clk);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_data", out_data, base + 32'(w));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    done = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(start), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_mem_read_data", mem_read_data, 32'd0);
    check_eq("rst_addr_err", 32'(addr_err), 32'd0);
    check_eq("message_addr", 32'(message_addr), 32'h0000);
    check_eq("output_addr", 32'(output_addr), 32'h0080);
    reset_n = 1'b1;

    // Job 1: done held high after start must not count as completion.
    load_job(32'h0000_0000);
    repeat (10) @(negedge clk);
    check_eq("ack_hold_no_dump", 32'(out_valid), 32'd0);
    check_eq("ack_hold_busy", 32'(busy), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 20; i++) eng_read("ram_readback", 16'(i), 32'(i));
    eng_write(16'h0005, 32'hDEAD_BEEF);
    eng_read("rw_deadbeef", 16'h0005, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_we = 1'b1;
    mem_addr = 16'h0006;
    mem_write_data = 32'h1;
    @(negedge clk);
    mem_we = 1'b0;
    check_eq("read_first_old", mem_read_data, 32'h0000_0006);
    eng_read("read_first_new", 16'h0006, 32'h1);
    check_eq("addr_err_clear", 32'(addr_err), 32'd0);
    eng_write(16'h0000, 32'h55AA_55AA);
    eng_write(16'h0100, 32'h1234_5678);
    check_eq("addr_err_set", 32'(addr_err), 32'd1);
    eng_read("oob_read_zero", 16'h0100, 32'd0);
    eng_read("oob_write_dropped", 16'h0000, 32'h55AA_55AA);
    for (int i = 0; i < 8; i++) eng_write(16'h0080 + 16'(i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    mem_addr = '0;
    done = 1'b1;
    dump_words(1'b1, 8, 32'hA000_0000);
    check_eq("job1_in_ready", 32'(in_ready), 32'd1);
    check_eq("job1_busy", 32'(busy), 32'd0);
    check_eq("job1_out_valid", 32'(out_valid), 32'd0);

    // Job 2: three-cycle done-low pulse, then reset in the middle of the dump.
    load_job(32'h0000_0100);
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    dump_words(1'b0, 3, 32'hA000_0000);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_addr_err", 32'(addr_err), 32'd0);
    reset_n = 1'b1;

    // Job 3: normal job after the abort; hash words persist across reset.
    load_job(32'h0000_0200);
    @(negedge clk);
    done = 1'b0;
    eng_read("job3_first_word", 16'h0000, 32'h0000_0200);
    eng_read("job3_last_word", 16'h0013, 32'h0000_0213);
    @(negedge clk);
    done = 1'b1;
    dump_words(1'b0, 8, 32'hA000_0000);
    check_eq("job3_in_ready", 32'(in_ready), 32'd1);
    check_eq("start_pulse_count", 32'(start_pulses), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
